cq_dispatch_arbiter: RTL and testbench

- Shares one tile's task-queue dequeue port and its Commit Queue slice among the tile's N_THREADS cores.
- Arbitrates round-robin between core dispatch requests.
- Allocates a CQ slot ID from a free list for each dispatch and returns slot IDs on commit/abort.
- Enforces the runtime CQ size limit (CQ_CONFIG) and supports host-driven drain.

---
 rtl/cq_dispatch_arbiter_pkg.sv | 18 +
 rtl/cq_dispatch_arbiter_free_list.sv | 56 +++++
 rtl/cq_dispatch_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cq_dispatch_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cq_dispatch_arbiter_pkg.sv
// Shared sizing defaults and types for the CQ dispatch arbiter.
package chronos;

    localparam int DEF_N_THREADS         = 32;
    localparam int DEF_LOG_CQ_SLICE_SIZE = 7;
    localparam int DEF_CQ_SLOTS          = 2 ** DEF_LOG_CQ_SLICE_SIZE;
    localparam int DEF_THREAD_ID_W       = $clog2(DEF_N_THREADS);

    typedef logic [DEF_LOG_CQ_SLICE_SIZE-1:0] cq_slot_t;
    typedef logic [DEF_THREAD_ID_W-1:0]       thread_id_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dispatch_state_t;

endpackage

// File: rtl/cq_dispatch_arbiter_free_list.sv
// Free list of CQ slot IDs: synchronous FIFO of 2**LOG_DEPTH entries with occupancy count.
module cq_slot_free_list
    import chronos::*;
#(
    parameter int LOG_DEPTH = DEF_LOG_CQ_SLICE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [LOG_DEPTH-1:0] push_data,
    input  logic                 pop,
    output logic [LOG_DEPTH-1:0] pop_data,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_W = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] ONE_W  = (LOG_DEPTH+1)'(1);

    logic [LOG_DEPTH-1:0] mem_r [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_r;
    logic [LOG_DEPTH-1:0] rd_ptr_r;
    logic [LOG_DEPTH:0]   count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Pops read stored entries only, so an empty list never forwards a same-cycle push.
    assign do_pop_s  = pop && (count_r != '0);
    assign do_push_s = push && (count_r != FULL_W);
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and count bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= do_push_s ? wr_ptr_r + {{(LOG_DEPTH-1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? rd_ptr_r + {{(LOG_DEPTH-1){1'b0}}, 1'b1} : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + ONE_W;
                2'b01:   count_r <= count_r - ONE_W;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/cq_dispatch_arbiter.sv
// Round-robin dispatch arbiter sharing one tile's task-queue dequeue port and CQ slice.
// Build macro DISPATCH_STATS_EN adds the stat_stall_cycles counter output.
module cq_dispatch_arbiter
    import chronos::*;
#(
    parameter int N_THREADS         = DEF_N_THREADS,
    parameter int LOG_CQ_SLICE_SIZE = DEF_LOG_CQ_SLICE_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_THREADS-1:0]         thread_req,
    output logic [N_THREADS-1:0]         thread_gnt,
    output logic [LOG_CQ_SLICE_SIZE-1:0] gnt_slot,
    input  logic                         tq_valid,
    output logic                         tq_deq,
    input  logic                         cq_release_valid,
    input  logic [LOG_CQ_SLICE_SIZE-1:0] cq_release_slot,
    input  logic [LOG_CQ_SLICE_SIZE:0]   cfg_cq_limit,
    input  logic                         cfg_drain,
    output logic                         drained,
    output logic [LOG_CQ_SLICE_SIZE:0]   occupancy,
    output logic                         init_done,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]                  stat_stall_cycles,
`endif
    output logic                         err_release
);
    localparam int LG = LOG_CQ_SLICE_SIZE;
    localparam int CQ_SLOTS = 2 ** LG;
    localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
    localparam logic [1:0]    ST_INIT  = INIT;
    localparam logic [1:0]    ST_RUN   = RUN;
    localparam logic [1:0]    ST_DRAIN = DRAIN;
    localparam logic [LG-1:0] LAST_SLOT = LG'(CQ_SLOTS - 1);
    localparam logic [LG:0]   SLOTS_W   = (LG+1)'(CQ_SLOTS);
    localparam logic [LG:0]   OCC_ONE   = (LG+1)'(1);
    localparam logic [TW:0]   NT_W      = (TW+1)'(N_THREADS);
    localparam logic [TW-1:0] LAST_THR  = TW'(N_THREADS - 1);

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [LG-1:0]        init_cnt_r;
    logic [TW-1:0]        rr_ptr_r;
    logic [N_THREADS-1:0] thread_gnt_r;
    logic [LG-1:0]        gnt_slot_r;
    logic                 tq_deq_r;
    logic                 drained_r;
    logic [LG:0]          occupancy_r;
    logic [LG:0]          occ_nxt_s;
    logic                 init_done_r;
    logic                 err_release_r;
    logic [N_THREADS-1:0] masked_req_s;
    logic                 pick_found_s;
    logic [TW-1:0]        pick_idx_s;
    logic                 fire_s;
    logic                 rel_ok_s;
    logic                 fl_push_s;
    logic [LG-1:0]        fl_push_data_s;
    logic [LG-1:0]        fl_pop_data_s;
    logic [LG:0]          fl_count_s;

    cq_slot_free_list #(.LOG_DEPTH(LG)) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (fl_push_s),
        .push_data (fl_push_data_s),
        .pop       (fire_s),
        .pop_data  (fl_pop_data_s),
        .count     (fl_count_s)
    );

    // INIT loads slot IDs in order; afterwards only accepted releases refill the list.
    assign fl_push_s      = (state_r == ST_INIT) || rel_ok_s;
    assign fl_push_data_s = (state_r == ST_INIT) ? init_cnt_r : cq_release_slot;
    assign masked_req_s   = thread_req & ~thread_gnt_r;

    assign fire_s = (state_r == ST_RUN) && !cfg_drain && tq_valid && (fl_count_s != '0)
                  && (occupancy_r < cfg_cq_limit) && pick_found_s;
    assign rel_ok_s = cq_release_valid && (state_r != ST_INIT) && (occupancy_r != '0)
                    && (fl_count_s != SLOTS_W);

    // Circular scan of unmasked requests starting at the round-robin pointer.
    always_comb begin : rr_scan
        logic [TW:0] idx_v;
        logic        hit_v;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        idx_v        = '0;
        hit_v        = 1'b0;
        for (int k = 0; k < N_THREADS; k++) begin
            idx_v        = {1'b0, rr_ptr_r} + (TW+1)'(k);
            idx_v        = (idx_v >= NT_W) ? idx_v - NT_W : idx_v;
            hit_v        = !pick_found_s && masked_req_s[idx_v[TW-1:0]];
            pick_idx_s   = hit_v ? idx_v[TW-1:0] : pick_idx_s;
            pick_found_s = pick_found_s | hit_v;
        end
    end

    // Next control state.
    always_comb begin
        case (state_r)
            ST_INIT:  state_nxt_s = (init_cnt_r == LAST_SLOT) ? ST_RUN : ST_INIT;
            ST_RUN:   state_nxt_s = cfg_drain ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = cfg_drain ? ST_DRAIN : ST_RUN;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // Next occupancy; a simultaneous grant and release cancel out.
    always_comb begin
        case ({fire_s, rel_ok_s})
            2'b10:   occ_nxt_s = occupancy_r + OCC_ONE;
            2'b01:   occ_nxt_s = occupancy_r - OCC_ONE;
            default: occ_nxt_s = occupancy_r;
        endcase
    end

    // Control state, registered grant outputs and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= '0;
            rr_ptr_r      <= '0;
            thread_gnt_r  <= '0;
            gnt_slot_r    <= '0;
            tq_deq_r      <= 1'b0;
            drained_r     <= 1'b0;
            occupancy_r   <= '0;
            init_done_r   <= 1'b0;
            err_release_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            init_cnt_r    <= (state_r == ST_INIT) ? init_cnt_r + {{(LG-1){1'b0}}, 1'b1} : init_cnt_r;
            init_done_r   <= init_done_r | ((state_r == ST_INIT) && (init_cnt_r == LAST_SLOT));
            thread_gnt_r  <= fire_s ? ({{(N_THREADS-1){1'b0}}, 1'b1} << pick_idx_s) : '0;
            gnt_slot_r    <= fire_s ? fl_pop_data_s : gnt_slot_r;
            tq_deq_r      <= fire_s;
            rr_ptr_r      <= !fire_s ? rr_ptr_r :
                             (pick_idx_s == LAST_THR) ? '0 : pick_idx_s + {{(TW-1){1'b0}}, 1'b1};
            occupancy_r   <= occ_nxt_s;
            drained_r     <= (state_nxt_s == ST_DRAIN) && (occ_nxt_s == '0);
            err_release_r <= err_release_r | (cq_release_valid & ~rel_ok_s);
        end
    end

    assign thread_gnt  = thread_gnt_r;
    assign gnt_slot    = gnt_slot_r;
    assign tq_deq      = tq_deq_r;
    assign drained     = drained_r;
    assign occupancy   = occupancy_r;
    assign init_done   = init_done_r;
    assign err_release = err_release_r;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cnt_r;
    logic        stall_s;

    assign stall_s = (state_r == ST_RUN) && (|thread_req) && tq_valid
                   && ((fl_count_s == '0) || (occupancy_r >= cfg_cq_limit));

    // Saturating count of dispatch cycles lost to an empty free list or reached limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stat_stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_cq_dispatch_arbiter.sv
// Randomized scoreboard bench for cq_dispatch_arbiter against a queue-based reference model.
module tb_cq_dispatch_arbiter;
    localparam int NT    = 32;
    localparam int LG    = 7;
    localparam int SLOTS = 128;
    localparam int P_INIT = 0, P_RUN = 1, P_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NT-1:0] thread_req;
    logic [NT-1:0] thread_gnt;
    logic [LG-1:0] gnt_slot;
    logic          tq_valid;
    logic          tq_deq;
    logic          cq_release_valid;
    logic [LG-1:0] cq_release_slot;
    logic [LG:0]   cfg_cq_limit;
    logic          cfg_drain;
    logic          drained;
    logic [LG:0]   occupancy;
    logic          init_done;
    logic          err_release;
`ifdef DISPATCH_STATS_EN
    logic [31:0]   stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    cq_dispatch_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .thread_req       (thread_req),
        .thread_gnt       (thread_gnt),
        .gnt_slot         (gnt_slot),
        .tq_valid         (tq_valid),
        .tq_deq           (tq_deq),
        .cq_release_valid (cq_release_valid),
        .cq_release_slot  (cq_release_slot),
        .cfg_cq_limit     (cfg_cq_limit),
        .cfg_drain        (cfg_drain),
        .drained          (drained),
        .occupancy        (occupancy),
        .init_done        (init_done),
`ifdef DISPATCH_STATS_EN
        .stat_stall_cycles(stat_stall_cycles),
`endif
        .err_release      (err_release)
    );

    typedef struct { int cyc; int thr; int slot; } exp_t;
    exp_t exp_q[$];

    // Reference model state: free slots in FIFO order, outstanding slots, counters.
    int            m_free[$];
    int            m_out[$];
    int            m_occ, m_rr, m_phase;
    logic [NT-1:0] m_last_gnt;
    bit            m_init_done, m_err, m_drained;
    longint        m_stall;

    int edge_cnt   = 0;
    int compared   = 0;
    int mismatched = 0;

    task automatic apply(input bit r, input logic [NT-1:0] req, input bit tqv, input bit relv,
                         input int rslot, input int lim, input bit drn);
        int  win;
        int  slot;
        int  pos;
        bit  rel_ok;
        rst = r; thread_req = req; tq_valid = tqv; cq_release_valid = relv;
        cq_release_slot = LG'(rslot); cfg_cq_limit = (LG+1)'(lim); cfg_drain = drn;
        if (r) begin
            m_free.delete(); m_out.delete();
            m_occ = 0; m_rr = 0; m_phase = P_INIT; m_last_gnt = '0;
            m_init_done = 0; m_err = 0; m_drained = 0; m_stall = 0;
        end else begin
            win = -1;
            if (m_phase == P_RUN && !drn && tqv && m_free.size() > 0 && m_occ < lim) begin
                for (int k = 0; k < NT; k++) begin
                    int i = (m_rr + k) % NT;
                    if (win < 0 && req[i] && !m_last_gnt[i]) win = i;
                end
            end
            if (m_phase == P_RUN && (req != '0) && tqv && (m_free.size() == 0 || m_occ >= lim)
                && m_stall < 64'hFFFF_FFFF) m_stall++;
            rel_ok = relv && m_phase != P_INIT && m_occ > 0;
            if (relv && !rel_ok) m_err = 1;
            m_last_gnt = '0;
            if (win >= 0) begin
                slot = m_free.pop_front();
                m_last_gnt[win] = 1'b1;
                m_out.push_back(slot);
                m_rr = (win + 1) % NT;
                m_occ++;
                exp_q.push_back('{edge_cnt + 1, win, slot});
            end
            if (rel_ok) begin
                m_free.push_back(rslot);
                pos = -1;
                foreach (m_out[j]) if (m_out[j] == rslot) pos = j;
                if (pos >= 0) m_out.delete(pos);
                m_occ--;
            end
            if (m_phase == P_INIT) begin
                m_free.push_back(m_free.size());
                if (m_free.size() == SLOTS) begin
                    m_phase = P_RUN;
                    m_init_done = 1;
                end
            end else if (m_phase == P_RUN && drn) m_phase = P_DRAIN;
            else if (m_phase == P_DRAIN && !drn) m_phase = P_RUN;
            m_drained = (m_phase == P_DRAIN) && (m_occ == 0);
        end
    endtask

    task automatic cycle(input bit r, input logic [NT-1:0] req, input bit tqv, input bit relv,
                         input int rslot, input int lim, input bit drn);
        @(negedge clk);
        apply(r, req, tqv, relv, rslot, lim, drn);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and pops the scoreboard.
    initial begin
        exp_t          e;
        logic [NT-1:0] one;
        bit            want;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            want = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
            if (want) begin
                e = exp_q.pop_front();
                one = '0;
                one[e.thr] = 1'b1;
                chk("thread_gnt", 64'(thread_gnt), 64'(one));
                chk("gnt_slot", 64'(gnt_slot), 64'(e.slot));
            end else begin
                chk("thread_gnt_idle", 64'(thread_gnt), 64'd0);
            end
            chk("tq_deq", 64'(tq_deq), 64'(want));
            chk("occupancy", 64'(occupancy), 64'(m_occ));
            chk("drained", 64'(drained), 64'(m_drained));
            chk("init_done", 64'(init_done), 64'(m_init_done));
            chk("err_release", 64'(err_release), 64'(m_err));
`ifdef DISPATCH_STATS_EN
            chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stall));
`endif
        end
    end

    initial begin
        logic [NT-1:0] req;
        bit            tqv, relv, drn;
        int            rslot, lim, guard;

        apply(1, '0, 0, 0, 0, 128, 0);
        repeat (3) cycle(1, '0, 0, 0, 0, 128, 0);

        // Init with requests pending, then back-to-back round-robin grants.
        repeat (130) cycle(0, '1, 1, 0, 0, 128, 0);
        repeat (40)  cycle(0, '1, 1, 0, 0, 128, 0);
        guard = 0;
        while (m_occ < SLOTS && guard < 300) begin
            cycle(0, '1, 1, 0, 0, 128, 0);
            guard++;
        end
        // Full CQ: release and request together, grant only follows a cycle later.
        cycle(0, '1, 1, 1, m_out[0], 128, 0);
        repeat (3) cycle(0, '1, 1, 0, 0, 128, 0);

        // Mid-operation reset, then a limit of four outstanding slots.
        repeat (2) cycle(1, '1, 1, 0, 0, 4, 0);
        repeat (128) cycle(0, '0, 1, 0, 0, 4, 0);
        repeat (10) cycle(0, '1, 1, 0, 0, 4, 0);
        cycle(0, '1, 1, 1, 2, 4, 0);
        repeat (5) cycle(0, '1, 1, 0, 0, 4, 0);

        // Drain with three slots outstanding.
        repeat (2) cycle(1, '0, 0, 0, 0, 3, 0);
        repeat (128) cycle(0, '0, 0, 0, 0, 3, 0);
        repeat (6) cycle(0, '1, 1, 0, 0, 3, 0);
        repeat (2) cycle(0, '1, 1, 0, 0, 3, 1);
        repeat (3) cycle(0, '1, 1, 1, m_out[0], 3, 1);
        repeat (2) cycle(0, '1, 1, 0, 0, 3, 1);
        repeat (5) cycle(0, '1, 1, 0, 0, 3, 0);
        // Blocked by a zero limit, then return everything and release once too often.
        repeat (10) cycle(0, '1, 1, 0, 0, 0, 0);
        while (m_out.size() > 0) cycle(0, '0, 0, 1, m_out[0], 0, 0);
        cycle(0, '0, 0, 1, 5, 0, 0);
        repeat (3) cycle(0, '0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        repeat (2) cycle(1, '0, 0, 0, 0, 128, 0);
        repeat (128) cycle(0, '0, 0, 0, 0, 128, 0);
        lim = 128;
        drn = 0;
        for (int c = 0; c < 2000; c++) begin
            req   = NT'($urandom() & $urandom());
            tqv   = ($urandom_range(0, 9) != 0);
            relv  = (m_out.size() > 0) && ($urandom_range(0, 2) == 0);
            rslot = relv ? m_out[$urandom_range(0, m_out.size() - 1)] : 0;
            if ($urandom_range(0, 199) == 0) lim = $urandom_range(0, 128);
            if ($urandom_range(0, 299) == 0) drn = !drn;
            cycle(0, req, tqv, relv, rslot, lim, drn);
        end
        repeat (4) cycle(0, '0, 0, 0, 0, lim, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
